sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8-bit wr/rd/din/dout/empty/full FIFO.
//  Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty,
//  read-data valid strobe, overflow/underflow error pulses, optional first-word-fall-through.
//  Sits between producer/consumer datapaths in the same clock domain.
// PARAMETERS
//  DATA_W     8           data word width in bits (>=1)
//  DEPTH      16          number of entries; power of two, >=4
//  AF_THRESH  DEPTH-2     almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2           almost_empty asserted when count <= AE_THRESH
// PORTS
//  clk           in   1                  clock, all logic on rising edge
//  rst           in   1                  synchronous active-high reset
//  wr            in   1                  write request
//  din           in   DATA_W             write data
//  rd            in   1                  read request (acknowledge in FWFT mode)
//  dout          out  DATA_W             read data
//  dout_valid    out  1                  dout holds a newly read word
//  full          out  1                  count == DEPTH
//  empty         out  1                  count == 0
//  almost_full   out  1                  count >= AF_THRESH
//  almost_empty  out  1                  count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  overflow      out  1                  1-cycle pulse: write rejected previous cycle
//  underflow     out  1                  1-cycle pulse: read rejected previous cycle
// BEHAVIOUR
//  - Reset: one clock, synchronous active-high (clk, rst). wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory not cleared.
//  - Reset mid-operation wins over same-cycle wr/rd; all stored words discarded.
//  - rd_acc = rd & ~empty. wr_acc = wr & (~full | rd): write into full FIFO accepted only with same-cycle read.
//  - Simultaneous wr_acc & rd_acc: count unchanged; on empty FIFO the read is rejected, write accepted.
//  - Write: mem[wr_ptr] <= din, wr_ptr+1. Read: rd_ptr+1. Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
//  - count += wr_acc - rd_acc; never exceeds DEPTH nor drops below 0.
//  - All flags registered, derived from next count; valid the cycle after the causing edge.
//  - overflow <= wr & ~wr_acc; underflow <= rd & ~rd_acc; each high exactly one cycle per rejected request.
//    Rejected requests change no pointer, count or data.
//  - Standard mode: on rd_acc, dout <= mem[rd_ptr], dout_valid <= 1 (latency 1 clk); otherwise
//    dout holds previous value, dout_valid <= 0.
//  - Word written to empty FIFO readable earliest next cycle (empty deasserts 1 clk after write).
// CONFIGURATION
//  - FIFO_FWFT_EN defined: first-word-fall-through. dout = mem[rd_ptr] whenever ~empty (0 when empty),
//    dout_valid = ~empty; rd acknowledges/pops the presented word, next word appears same cycle
//    as rd_ptr update. Write into empty FIFO visible on dout 1 clk after the write edge.
//  - FIFO_FWFT_EN undefined: standard registered-read mode above. Flags/counts identical in both modes.
// TESTING
//  1 Reset: assert rst 2 clks mid-traffic -> count=0, empty=1, dout=0, dout_valid=0, pulses low.
//  2 Order: DEPTH=16, write 1..16 -> full=1 after 16th, almost_full at count 14; read 16 -> 1..16 in
//    order, dout_valid 1 clk after each rd, empty=1 after last.
//  3 Overflow: full FIFO, wr=1 din=0xAA, rd=0 -> overflow pulses 1 clk, count stays 16, 0xAA never read.
//  4 Underflow: empty FIFO, rd=1 -> underflow pulses 1 clk, dout unchanged, count 0.
//  5 Simultaneous: full + wr&rd -> count 16, oldest word out, new word last; empty + wr&rd -> underflow, count 1.
//  6 Wrap: 40 interleaved writes/reads with count oscillating 3..12 -> data sequence preserved across
//    pointer wrap; repeat with FIFO_FWFT_EN: dout = head word while ~empty, 0x05 visible 1 clk after write.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; the default build uses a registered read port.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              empty_q, full_q, af_q, ae_q, ovf_q, udf_q;
    logic              rd_acc, wr_acc;

    // A write into a full FIFO is only safe when the same cycle frees a slot.
    always_comb begin
        rd_acc  = rd & ~empty_q;
        wr_acc  = wr & (~full_q | rd);
        count_d = count_q + CntW'(wr_acc) - CntW'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CntW'(DEPTH));
            af_q    <= (count_d >= CntW'(AF_THRESH));
            ae_q    <= (count_d <= CntW'(AE_THRESH));
            ovf_q   <= wr & ~wr_acc;
            udf_q   <= rd & ~rd_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally; rd acts as the pop acknowledge.
    always_comb begin
        dout       = empty_q ? '0 : mem[rd_ptr_q];
        dout_valid = ~empty_q;
    end
`else
    logic [DATA_W-1:0] dout_q;
    logic              dv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= rd_acc;
            if (rd_acc) dout_q <= mem[rd_ptr_q];
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed table, hand-written corner sequences and random traffic
// against a queue-based reference model. Follows FIFO_FWFT_EN to select the expected read behaviour.
module tb_sync_fifo_param;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0, rd = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
        .dout_valid(dout_valid), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the last registered read result.
    logic [7:0] mq[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        int         exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = 8'h00;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic [7:0] d);
        logic rd_ok, wr_ok;
        rd_ok = r && (mq.size() != 0);
        wr_ok = w && ((mq.size() < DEPTH) || r);
        m_dv  = 1'b0;
        if (rd_ok) begin
            m_dout = mq.pop_front();
            m_dv   = 1'b1;
        end
        if (wr_ok) mq.push_back(d);
        m_ovf = w && !wr_ok;
        m_udf = r && !rd_ok;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - 2));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
        chk({tag, ".dout"}, 32'(dout), (n != 0) ? 32'(mq[0]) : 32'h0);
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(n != 0));
`else
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_dv));
`endif
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
    task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #1;
        model_step(w, r, d);
        wr = 1'b0;
        rd = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        wr  = 1'($urandom_range(0, 1));
        rd  = 1'($urandom_range(0, 1));
        din = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
        model_reset();
        chk({tag, ".rst_count"}, 32'(count), 32'h0);
        chk({tag, ".rst_empty"}, 32'(empty), 32'h1);
        chk({tag, ".rst_dout"}, 32'(dout), 32'h0);
        chk({tag, ".rst_dv"}, 32'(dout_valid), 32'h0);
        chk({tag, ".rst_pulses"}, 32'({overflow, underflow}), 32'h0);
        check_all(tag);
    endtask

    initial begin
        vec_t tbl[7];
        bit   up;
        tbl[0] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};

        do_reset("init");

        // Directed table from a fresh reset: underflow, wr&rd on empty, simple push/pop.
        for (int i = 0; i < 7; i++) begin
            step("tbl", tbl[i].w, tbl[i].r, tbl[i].d);
            chk("tbl.count", 32'(count), 32'(tbl[i].exp_count));
            chk("tbl.empty", 32'(empty), 32'(tbl[i].exp_empty));
            chk("tbl.full", 32'(full), 32'(tbl[i].exp_full));
            chk("tbl.overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
            chk("tbl.underflow", 32'(underflow), 32'(tbl[i].exp_udf));
        end

        // Fill 1..16, then overflow, then wr&rd while full, then drain.
        do_reset("fill");
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, 1'b0, 8'(i));
            if (i == 14) chk("fill.af_at14", 32'(almost_full), 32'h1);
            if (i == 13) chk("fill.af_at13", 32'(almost_full), 32'h0);
        end
        chk("fill.full16", 32'(full), 32'h1);
        step("ovf", 1'b1, 1'b0, 8'hAA);
        chk("ovf.pulse", 32'(overflow), 32'h1);
        chk("ovf.count", 32'(count), 32'd16);
        step("ovf_idle", 1'b0, 1'b0, 8'h00);
        chk("ovf.one_cycle", 32'(overflow), 32'h0);
        step("full_wrrd", 1'b1, 1'b1, 8'h77);
        chk("full_wrrd.count", 32'(count), 32'd16);
`ifndef FIFO_FWFT_EN
        chk("full_wrrd.oldest", 32'(dout), 32'h01);
`endif
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);
        chk("drain.empty", 32'(empty), 32'h1);
`ifndef FIFO_FWFT_EN
        chk("drain.last", 32'(dout), 32'h77);
`endif
        step("udf", 1'b0, 1'b1, 8'h00);
        chk("udf.pulse", 32'(underflow), 32'h1);
`ifndef FIFO_FWFT_EN
        chk("udf.dout_hold", 32'(dout), 32'h77);
`endif

        // Head word visible one edge after a write into an empty FIFO.
        do_reset("fwft");
        step("w05", 1'b1, 1'b0, 8'h05);
`ifdef FIFO_FWFT_EN
        chk("w05.head", 32'(dout), 32'h05);
`else
        chk("w05.no_dv", 32'(dout_valid), 32'h0);
`endif

        // Count oscillates 3..12 across several pointer wraps.
        up = 1'b1;
        while (mq.size() < 3) step("prefill", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 120; i++) begin
            if (mq.size() >= 12) up = 1'b0;
            if (mq.size() <= 3) up = 1'b1;
            step("wrap", up || ($urandom_range(0, 3) == 0), !up || ($urandom_range(0, 3) == 0),
                 8'($urandom));
        end

        // Unconstrained random traffic, with a reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("mid");
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
